// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   WORD_WIDTH   operand and HI/LO width
//   ALUOP_WIDTH  width of the decoded alu_op field
//   ALUOP_*      mul/div-class opcodes, kept alongside the ALU's own codes
//   state_t      muldiv_unit FSM states
package muldiv_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int ALUOP_WIDTH = 8;

    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MFHI  = 8'h10;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MTHI  = 8'h11;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MFLO  = 8'h12;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MTLO  = 8'h13;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MULT  = 8'h18;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MULTU = 8'h19;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_DIV   = 8'h1A;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_DIVU  = 8'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage bus between the pipeline and muldiv_unit.
//   master (pipeline): drives op1, op2, alu_op, start, flush;
//                      receives stall_req, done, hi, lo
//   slave  (unit):     the reverse
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int W = WORD_WIDTH
);
    logic [W-1:0]           op1;
    logic [W-1:0]           op2;
    logic [ALUOP_WIDTH-1:0] alu_op;
    logic                   start;
    logic                   flush;
    logic                   stall_req;
    logic                   done;
    logic [W-1:0]           hi;
    logic [W-1:0]           lo;

    modport master (
        output op1, op2, alu_op, start, flush,
        input  stall_req, done, hi, lo
    );

    modport slave (
        input  op1, op2, alu_op, start, flush,
        output stall_req, done, hi, lo
    );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: iterative unsigned datapath shared by multiply and divide.
//   clk, rst  clock and synchronous active-high reset
//   load      capture a (multiplier / dividend) and b (multiplicand / divisor)
//   step      advance one iteration; is_div selects restoring divide
//   next_hi   acc value after the current step (product high / remainder)
//   next_lo   shift register after the current step (product low / quotient)
//   last      the current step is the final iteration
module muldiv_core #(
    parameter int W    = 32,
    parameter int ITER = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] next_hi,
    output logic [W-1:0] next_lo,
    output logic         last
);
    localparam int CW = $clog2(ITER + 1);

    logic [W-1:0]  acc;
    logic [W-1:0]  sreg;
    logic [W-1:0]  opnd;
    logic [CW-1:0] count;

    logic [W:0]    sum;
    logic [W:0]    shifted;
    logic [W+1:0]  diff;

    // Multiply: add the multiplicand when the multiplier LSB is set, then
    // shift {acc, sreg} right so the product builds up from the bottom.
    // Divide: shift the next dividend bit into the remainder and keep the
    // trial subtraction only if it does not borrow.
    always_comb begin
        sum     = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        shifted = {acc, sreg[W-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};
        next_hi = acc;
        next_lo = sreg;
        if (is_div) begin
            if (!diff[W+1]) begin
                next_hi = diff[W-1:0];
            end else begin
                next_hi = shifted[W-1:0];
            end
            next_lo = {sreg[W-2:0], ~diff[W+1]};
        end else begin
            next_hi = sum[W:1];
            next_lo = {sum[0], sreg[W-1:1]};
        end
    end

    assign last = (count == CW'(ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            sreg  <= '0;
            opnd  <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= '0;
            sreg  <= a;
            opnd  <= b;
            count <= '0;
        end else if (step) begin
            acc   <= next_hi;
            sreg  <= next_lo;
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multiply/divide unit owning HI/LO.
//   clk, rst  clock and synchronous active-high reset
//   bus       muldiv_if.slave: op1/op2/alu_op/start/flush in;
//             stall_req (combinational), done pulse, hi, lo out
// Signed ops run on magnitudes in muldiv_core; signs are re-applied
// as the result is committed on the edge entering DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int W    = WORD_WIDTH,
    parameter int ITER = W
) (
    input  logic   clk,
    input  logic   rst,
    muldiv_if.slave bus
);
    state_t         state, state_n;
    logic [W-1:0]   hi_r, lo_r;
    logic           neg_q, neg_r, div_zero;
    logic [W-1:0]   raw_op1;

    logic           is_mul_op, is_div_op, is_signed;
    logic [W-1:0]   mag1, mag2;
    logic           core_load, core_step, core_last, commit;
    logic           mthi_wr, mtlo_wr;
    logic [W-1:0]   core_hi, core_lo;
    logic [2*W-1:0] prod_mag, prod_fix;
    logic [W-1:0]   res_hi, res_lo;

    assign is_mul_op = (bus.alu_op == ALUOP_MULT) || (bus.alu_op == ALUOP_MULTU);
    assign is_div_op = (bus.alu_op == ALUOP_DIV)  || (bus.alu_op == ALUOP_DIVU);
    assign is_signed = (bus.alu_op == ALUOP_MULT) || (bus.alu_op == ALUOP_DIV);
    assign mag1 = (is_signed && bus.op1[W-1]) ? -bus.op1 : bus.op1;
    assign mag2 = (is_signed && bus.op2[W-1]) ? -bus.op2 : bus.op2;

    muldiv_core #(.W(W), .ITER(ITER)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .step    (core_step),
        .is_div  (state == S_DIV),
        .a       (mag1),
        .b       (mag2),
        .next_hi (core_hi),
        .next_lo (core_lo),
        .last    (core_last)
    );

    always_comb begin
        state_n   = state;
        core_load = 1'b0;
        core_step = 1'b0;
        commit    = 1'b0;
        mthi_wr   = 1'b0;
        mtlo_wr   = 1'b0;
        bus.stall_req = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (is_mul_op) begin
                        state_n   = S_MUL;
                        core_load = 1'b1;
                    end else if (is_div_op) begin
                        state_n   = S_DIV;
                        core_load = 1'b1;
                    end else if (bus.alu_op == ALUOP_MTHI) begin
                        mthi_wr = 1'b1;
                    end else if (bus.alu_op == ALUOP_MTLO) begin
                        mtlo_wr = 1'b1;
                    end
                    bus.stall_req = is_mul_op || is_div_op;
                end
            end
            S_MUL, S_DIV: begin
                core_step     = 1'b1;
                bus.stall_req = 1'b1;
                if (core_last) begin
                    state_n = S_DONE;
                    commit  = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // A flush squashes everything, including a same-cycle MTHI/MTLO.
        if (bus.flush) begin
            state_n   = S_IDLE;
            core_load = 1'b0;
            core_step = 1'b0;
            commit    = 1'b0;
            mthi_wr   = 1'b0;
            mtlo_wr   = 1'b0;
        end
    end

    // Divide by zero bypasses sign fix-up and returns the raw dividend in HI.
    always_comb begin
        prod_mag = {core_hi, core_lo};
        prod_fix = neg_q ? -prod_mag : prod_mag;
        res_hi   = prod_fix[2*W-1:W];
        res_lo   = prod_fix[W-1:0];
        if (state == S_DIV) begin
            if (div_zero) begin
                res_hi = raw_op1;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -core_hi : core_hi;
                res_lo = neg_q ? -core_lo : core_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hi_r     <= '0;
            lo_r     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            raw_op1  <= '0;
        end else begin
            state <= state_n;
            if (core_load) begin
                neg_q    <= is_signed && (bus.op1[W-1] ^ bus.op2[W-1]);
                neg_r    <= is_signed && bus.op1[W-1];
                div_zero <= is_div_op && (bus.op2 == '0);
                raw_op1  <= bus.op1;
            end
            if (mthi_wr) hi_r <= bus.op1;
            if (mtlo_wr) lo_r <= bus.op1;
            if (commit) begin
                hi_r <= res_hi;
                lo_r <= res_lo;
            end
        end
    end

    assign bus.done = (state == S_DONE);
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   done_cyc;
    int   stall_cnt;
    int   done_seen;

    muldiv_if #(.W(32)) bus ();

    muldiv_unit #(.W(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one mul/div op and follow it until done (bounded to 100 cycles).
    // done_cycle is the cycle index of the done pulse (start cycle = 0).
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output int done_cycle,
                                 output int stall_count);
        @(negedge clk);
        bus.alu_op = op;
        bus.op1    = a;
        bus.op2    = b;
        bus.start  = 1'b1;
        #1;
        stall_count = bus.stall_req ? 1 : 0;
        done_cycle  = -1;
        for (int c = 1; c <= 100 && done_cycle < 0; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.stall_req) stall_count++;
            if (bus.done) done_cycle = c;
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        tests_run    = 0;
        tests_failed = 0;
        bus.op1    = '0;
        bus.op2    = '0;
        bus.alu_op = '0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_hi", bus.hi, 32'h0);
        checkOutput("reset_lo", bus.lo, 32'h0);
        checkOutput("reset_done", 32'(bus.done), 32'h0);
        checkOutput("reset_stall", 32'(bus.stall_req), 32'h0);

        applyStimulus(ALUOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, done_cyc, stall_cnt);
        checkOutput("multu_latency", 32'(done_cyc), 32'd33);
        checkOutput("multu_stall", 32'(stall_cnt), 32'd33);
        checkOutput("multu_hi", bus.hi, 32'hFFFFFFFE);
        checkOutput("multu_lo", bus.lo, 32'h00000001);
        @(negedge clk);
        #1;
        checkOutput("done_one_cycle", 32'(bus.done), 32'h0);

        applyStimulus(ALUOP_MULT, 32'hFFFFFFFE, 32'd3, done_cyc, stall_cnt);
        checkOutput("mult_latency", 32'(done_cyc), 32'd33);
        checkOutput("mult_hi", bus.hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", bus.lo, 32'hFFFFFFFA);

        applyStimulus(ALUOP_DIV, 32'hFFFFFFF9, 32'd2, done_cyc, stall_cnt);
        checkOutput("div_neg_lo", bus.lo, 32'hFFFFFFFD);
        checkOutput("div_neg_hi", bus.hi, 32'hFFFFFFFF);

        applyStimulus(ALUOP_DIVU, 32'd100, 32'd7, done_cyc, stall_cnt);
        checkOutput("divu_lo", bus.lo, 32'd14);
        checkOutput("divu_hi", bus.hi, 32'd2);

        applyStimulus(ALUOP_DIV, 32'h80000000, 32'hFFFFFFFF, done_cyc, stall_cnt);
        checkOutput("div_ovf_lo", bus.lo, 32'h80000000);
        checkOutput("div_ovf_hi", bus.hi, 32'h0);

        applyStimulus(ALUOP_DIVU, 32'd5, 32'd0, done_cyc, stall_cnt);
        checkOutput("divu0_latency", 32'(done_cyc), 32'd33);
        checkOutput("divu0_lo", bus.lo, 32'hFFFFFFFF);
        checkOutput("divu0_hi", bus.hi, 32'd5);

        applyStimulus(ALUOP_DIV, 32'hFFFFFFF9, 32'd0, done_cyc, stall_cnt);
        checkOutput("div0_neg_lo", bus.lo, 32'hFFFFFFFF);
        checkOutput("div0_neg_hi", bus.hi, 32'hFFFFFFF9);

        // MTHI / MTLO: no stall, visible one edge later
        @(negedge clk);
        bus.alu_op = ALUOP_MTHI;
        bus.op1    = 32'h1234;
        bus.start  = 1'b1;
        #1;
        checkOutput("mthi_stall", 32'(bus.stall_req), 32'h0);
        @(negedge clk);
        bus.alu_op = ALUOP_MTLO;
        bus.op1    = 32'h5678;
        #1;
        checkOutput("mthi_hi", bus.hi, 32'h1234);
        checkOutput("mtlo_stall", 32'(bus.stall_req), 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checkOutput("mtlo_lo", bus.lo, 32'h5678);

        // Non mul/div op with start is ignored
        bus.alu_op = ALUOP_MFHI;
        bus.op1    = 32'hDEAD;
        bus.start  = 1'b1;
        #1;
        checkOutput("ignored_stall", 32'(bus.stall_req), 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checkOutput("ignored_hi", bus.hi, 32'h1234);

        // flush beats a same-cycle MTHI
        bus.alu_op = ALUOP_MTHI;
        bus.op1    = 32'hBEEF;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        checkOutput("flush_mthi_hi", bus.hi, 32'h1234);

        // DIV flushed at count=10 (cycle 11)
        bus.alu_op = ALUOP_DIV;
        bus.op1    = 32'd100;
        bus.op2    = 32'd7;
        bus.start  = 1'b1;
        done_seen  = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.done) done_seen++;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checkOutput("flush_stall", 32'(bus.stall_req), 32'h0);
        for (int c = 0; c < 40; c++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
            #1;
        end
        checkOutput("flush_no_done", 32'(done_seen), 32'h0);
        checkOutput("flush_hi", bus.hi, 32'h1234);
        checkOutput("flush_lo", bus.lo, 32'h5678);

        // rst in cycle 5 of a MULT
        bus.alu_op = ALUOP_MULT;
        bus.op1    = 32'd9;
        bus.op2    = 32'd9;
        bus.start  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        checkOutput("pre_rst_stall", 32'(bus.stall_req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_hi", bus.hi, 32'h0);
        checkOutput("rst_lo", bus.lo, 32'h0);
        checkOutput("rst_stall", 32'(bus.stall_req), 32'h0);
        checkOutput("rst_done", 32'(bus.done), 32'h0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        checkOutput("rst_no_done", 32'(done_seen), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, beside the ALU; takes the same decoded operands and alu_op.
- Owns the architectural HI/LO registers and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO; HI/LO are read for MFHI/MFLO.
- Raises a stall request that freezes IF/ID/EX until a result is committed.

Parameters:
- W, `WORD_WIDTH (32), operand and HI/LO width.
- ITER, W (32), shift-add / restoring-divide iterations per operation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op1  in  W  rs operand, same value as the ALU's op1.
- op2  in  W  rt operand, same value as the ALU's op2.
- alu_op  in  `ALUOP_WIDTH  decoded op; this unit acts only on `MULT, `MULTU, `DIV, `DIVU, `MTHI, `MTLO.
- start  in  1  EX holds a valid mul/div-class instruction.
- flush  in  1  pipeline flush (exception/branch squash).
- stall_req  out  1  freeze request to the pipeline controller.
- done  out  1  one-cycle pulse when HI/LO have been committed by a mul/div.
- hi  out  W  current HI register.
- lo  out  W  current LO register.

Behaviour:
- Reset:
  - state=IDLE; hi=0, lo=0; done=0, stall_req=0.
  - Internal counter, accumulators and sign flags are cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start & MULT/MULTU: latch operands, go to MUL with count=0.
  - start & DIV/DIVU: latch operands, go to DIV with count=0.
  - Signed ops latch magnitudes plus sign flags (quotient/product sign = op1[W-1]^op2[W-1]; remainder sign = op1[W-1]).
  - start & MTHI: hi<=op1 next edge, stay IDLE, no stall. start & MTLO: lo<=op1 likewise.
  - start with any other alu_op: ignored.
- MUL: radix-2 shift-add, one partial product per cycle; after ITER cycles go to DONE.
- DIV: restoring division, one quotient bit per cycle; after ITER cycles go to DONE.
- DONE:
  - {hi,lo} written at entry edge: MUL gives hi=product[2W-1:W], lo=product[W-1:0]; DIV gives lo=quotient, hi=remainder.
  - Sign correction is applied before the write.
  - done=1 for exactly this cycle; next state IDLE.
- Latency: start accepted at edge 0; done high in cycle ITER+1; the new hi/lo are visible in that same cycle.
- stall_req (combinational):
  - High when state is IDLE with start and alu_op in {MULT,MULTU,DIV,DIVU}.
  - High in every MUL and DIV cycle.
  - Low in DONE, so the instruction retires.
- Arithmetic rules:
  - MULTU/DIVU use unsigned operands.
  - MULT yields the full 2W-bit two's-complement product.
  - Divide by zero: lo=all-ones, hi=op1 (raw op1, no sign fix); completes in normal latency.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0.
- flush:
  - From any state, next state is IDLE; an in-flight operation is abandoned; hi/lo unchanged; done stays 0.
  - flush wins over start and over an MTHI/MTLO in the same cycle.
- start while MUL/DIV/DONE: ignored; the pipeline is stalled, so this only occurs on a flush-replay.
- rst mid-operation: same result as power-on reset; partial results are discarded.

Decomposition:
- `ALUOP codes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO and state encodings go in defines.v, next to the existing ALU ops.
- One natural sub-module: muldiv_core. It holds the iterative datapath (accumulator, shift register, counter) with load/step/finish controls.
- The FSM, sign handling and HI/LO registers live in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> stall_req high 33 cycles; done in cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFE (−2) × 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV −7 ÷ 2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU 100 ÷ 7 -> lo=14, hi=2. DIV 0x80000000 ÷ −1 -> lo=0x80000000, hi=0.
- DIVU 5 ÷ 0 -> lo=0xFFFFFFFF, hi=5, done at normal latency.
- MTHI 0x1234 then MTLO 0x5678 -> no stall; hi/lo updated one edge later. Then start DIV, flush at count=10 -> IDLE next cycle, done never pulses, hi/lo remain 0x1234/0x5678.
- rst asserted in cycle 5 of a MULT -> next cycle state IDLE; hi=lo=0, stall_req=0, done=0.
